hiscore_upload: RTL
===================

Name: hiscore_upload

Overview:
- Responder for the HPS ioctl upload path; the counterpart of the ROM download path.
- Serves ioctl_rd requests by reading the core's work/hiscore RAM through a read port, so that save data can be pulled out to the SD card.
- Holds the galaxian CPU paused while an upload is active, so RAM contents stay stable.
- Sits between hps_io and the game core inside emu.

Parameters:
- ADDR_W, 10, width of the RAM address.
- SIZE, 1024, number of bytes in the save region (1..2^ADDR_W).
- RAM_LAT, 1, read latency of the RAM port in cycles (1..3).
- INDEX, 8'd4, ioctl_index value this block answers to.

Ports:
- clk_sys  in  1  system clock, 12 MHz core clock.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_index  in  8  upload target selector.
- ioctl_rd  in  1  one-cycle read strobe; ioctl_addr is valid in the same cycle.
- ioctl_addr  in  25  byte address being read.
- ioctl_din  out  8  byte returned to the HPS.
- ioctl_wait  out  1  high while the byte is not yet valid.
- pause_req  out  1  request to the core to halt the CPU.
- pause_ack  in  1  core is halted.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rd  out  1  one-cycle RAM read enable.
- ram_dout  in  8  RAM read data, valid RAM_LAT cycles after ram_rd.

Behaviour:
- Reset: all outputs 0 (ioctl_din 8'h00, ioctl_wait 0, pause_req 0, ram_rd 0, ram_addr 0). FSM goes to IDLE.
- active = ioctl_upload & (ioctl_index == INDEX).
- FSM states: IDLE, PAUSE, READY, FETCH, HOLD.
- IDLE: on active, set pause_req=1 and go to PAUSE.
- PAUSE: wait for pause_ack=1, then go to READY.
  - An ioctl_rd in PAUSE is latched in a one-deep pending register.
  - ioctl_wait goes 1 the cycle after the strobe.
- READY: on ioctl_rd (or a pending strobe), register ioctl_addr and set ioctl_wait=1 from the next cycle.
  - If addr < SIZE: pulse ram_rd=1 for one cycle with ram_addr=addr[ADDR_W-1:0], load a latency counter with RAM_LAT, go to FETCH.
  - If addr ≥ SIZE: ioctl_din=8'hFF, go to HOLD directly (no RAM access).
- FETCH: decrement the counter. When it reaches 0, capture ram_dout into ioctl_din, drop ioctl_wait, go to HOLD.
  - Total latency from ioctl_rd to ioctl_wait=0 is RAM_LAT+1 cycles.
- HOLD: ioctl_din stays stable until the next accepted strobe. Go back to READY in the same cycle.
- A strobe arriving in FETCH is latched as pending, served after the current byte, and never dropped.
  - A second strobe while one is already pending is a protocol error and is ignored.
- Deassertion of active in any state:
  - abort any fetch and clear the pending strobe;
  - ioctl_wait=0, and pause_req=0 on the next cycle;
  - go to IDLE; ioctl_din keeps its last value.
- pause_ack dropping while active: return to PAUSE and keep ioctl_wait=1 until it reasserts.
- Address compare uses the full 25-bit ioctl_addr, so upper bits set means out of range.
- Asynchronous reset mid-operation releases pause_req immediately.

Optional Feature:
- Macro: HISCORE_CHECKSUM_EN.
- When defined:
  - an 8-bit XOR accumulator clears on entry to PAUSE;
  - it XORs in each byte captured from RAM;
  - address SIZE returns the accumulator instead of 8'hFF, so the upload length is SIZE+1;
  - addresses above SIZE still return 8'hFF.
- When undefined: no accumulator logic, and address SIZE returns 8'hFF.

Decomposition:
- Package hiscore_pkg holds:
  - the state enum (IDLE, PAUSE, READY, FETCH, HOLD);
  - the constant OOR_BYTE = 8'hFF;
  - the default INDEX constant.
- One sub-module, hiscore_lat_cnt: a loadable down-counter with a zero flag, sized by RAM_LAT.

Test Plan:
- Index mismatch: ioctl_upload=1 with ioctl_index=8'd0 → pause_req stays 0 and ioctl_rd is ignored (ioctl_wait stays 0).
- Basic read: index 4, pause_ack 3 cycles after pause_req, RAM[0x005]=8'hA5, rd addr 5, RAM_LAT=2 → ram_rd pulse with ram_addr=5, ioctl_wait high 3 cycles, then ioctl_din=8'hA5.
- Out of range: rd addr 1024 (SIZE=1024) → no ram_rd, ioctl_din=8'hFF after 1 cycle of wait; addr 25'h100005 → 8'hFF.
- Early strobe: ioctl_rd during PAUSE before pause_ack → served after ack with the correct byte; back-to-back strobe during FETCH → both bytes returned in order.
- Abort: ioctl_upload drops during FETCH → ioctl_wait=0 immediately, pause_req=0 the next cycle, state IDLE; a new session starts cleanly.
- Checksum (HISCORE_CHECKSUM_EN, SIZE=4, RAM={01,02,04,08}): read addrs 0..4 → last byte 8'h0F; address 5 → 8'hFF.

Source files
------------

// File: rtl/hiscore_pkg.sv
// Shared types and constants for the hiscore upload responder.
package hiscore_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PAUSE = 3'd1,
    READY = 3'd2,
    FETCH = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int         IOCTL_AW      = 25;
  localparam logic [7:0] OOR_BYTE      = 8'hFF;
  localparam logic [7:0] DEFAULT_INDEX = 8'd4;

endpackage

// File: rtl/hiscore_lat_cnt.sv
// Loadable down-counter that times the RAM read latency; zero marks data valid.
module hiscore_lat_cnt #(
  parameter int RAM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(RAM_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(RAM_LAT);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hiscore_upload.sv
// HPS ioctl upload responder: pauses the core and serves save-RAM bytes to ioctl_rd.
// Optional HISCORE_CHECKSUM_EN appends an XOR checksum byte at address SIZE.
module hiscore_upload
  import hiscore_pkg::*;
#(
  parameter int         ADDR_W  = 10,
  parameter int         SIZE    = 1024,
  parameter int         RAM_LAT = 1,
  parameter logic [7:0] INDEX   = DEFAULT_INDEX
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic                pause_req,
  input  logic                pause_ack,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_rd,
  input  logic [7:0]          ram_dout
);

  localparam logic [IOCTL_AW-1:0] SIZE_A = IOCTL_AW'(SIZE);

  state_t state, state_nxt;

  logic                active;
  logic                pend;
  logic [IOCTL_AW-1:0] pend_addr;
  logic [IOCTL_AW-1:0] serve_addr;
  logic                in_range;
  logic [7:0]          oor_data;

  logic serve, latch, capture, set_wait, clr_wait, start_pause, abort;
  logic cnt_load, cnt_dec, cnt_zero;

  logic              wait_p1;
  logic              pause_p1;
  logic              ram_rd_p1;
  logic [ADDR_W-1:0] ram_addr_p1;
  logic [7:0]        din_p1;

  assign active     = ioctl_upload && (ioctl_index == INDEX);
  assign serve_addr = pend ? pend_addr : ioctl_addr;
  assign in_range   = (serve_addr < SIZE_A);
  assign cnt_load   = serve && in_range;

`ifdef HISCORE_CHECKSUM_EN
  logic [7:0] acc;

  // Running XOR of every byte captured from RAM since the session started.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (start_pause) begin
      acc <= '0;
    end else if (capture) begin
      acc <= acc ^ ram_dout;
    end
  end

  assign oor_data = (serve_addr == SIZE_A) ? acc : OOR_BYTE;
`else
  assign oor_data = OOR_BYTE;
`endif

  hiscore_lat_cnt #(
    .RAM_LAT (RAM_LAT)
  ) u_lat_cnt (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    serve       = 1'b0;
    latch       = 1'b0;
    capture     = 1'b0;
    set_wait    = 1'b0;
    clr_wait    = 1'b0;
    start_pause = 1'b0;
    abort       = 1'b0;
    cnt_dec     = 1'b0;
    if (!active) begin
      abort     = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          start_pause = 1'b1;
          latch       = ioctl_rd;
          set_wait    = ioctl_rd;
          state_nxt   = PAUSE;
        end
        PAUSE: begin
          latch    = ioctl_rd && !pend;
          set_wait = ioctl_rd;
          if (pause_ack) state_nxt = READY;
        end
        READY, HOLD: begin
          if (!pause_ack) begin
            latch     = ioctl_rd && !pend;
            set_wait  = 1'b1;
            state_nxt = PAUSE;
          end else if (ioctl_rd || pend) begin
            // A pending strobe is served first; a fresh one alongside it queues.
            serve     = 1'b1;
            latch     = ioctl_rd && pend;
            set_wait  = 1'b1;
            state_nxt = in_range ? FETCH : HOLD;
          end else begin
            clr_wait  = 1'b1;
            state_nxt = READY;
          end
        end
        FETCH: begin
          latch   = ioctl_rd && !pend;
          cnt_dec = 1'b1;
          if (cnt_zero) begin
            capture   = 1'b1;
            clr_wait  = 1'b1;
            state_nxt = HOLD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend        <= 1'b0;
      wait_p1     <= 1'b0;
      pause_p1    <= 1'b0;
      ram_rd_p1   <= 1'b0;
      ram_addr_p1 <= '0;
      din_p1      <= '0;
    end else begin
      if (abort) begin
        pend <= 1'b0;
      end else if (latch) begin
        pend <= 1'b1;
      end else if (serve && pend) begin
        pend <= 1'b0;
      end

      if (abort) begin
        wait_p1 <= 1'b0;
      end else if (set_wait) begin
        wait_p1 <= 1'b1;
      end else if (clr_wait) begin
        wait_p1 <= 1'b0;
      end

      if (abort) begin
        pause_p1 <= 1'b0;
      end else if (start_pause) begin
        pause_p1 <= 1'b1;
      end

      ram_rd_p1 <= serve && in_range;
      if (serve && in_range) ram_addr_p1 <= serve_addr[ADDR_W-1:0];

      if (serve && !in_range) begin
        din_p1 <= oor_data;
      end else if (capture) begin
        din_p1 <= ram_dout;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (latch) pend_addr <= ioctl_addr;
  end

  // Wait drops combinationally so an aborted session releases the HPS at once.
  assign ioctl_wait = wait_p1 && active;
  assign pause_req  = pause_p1;
  assign ram_rd     = ram_rd_p1;
  assign ram_addr   = ram_addr_p1;
  assign ioctl_din  = din_p1;

endmodule
